// File: rtl/apu_ram_pkg.sv
// apu_ram_pkg: shared widths, owner encoding and streak limit for the audio RAM arbiter
package apu_ram_pkg;
    localparam int APU_ADDR_W = 16;
    localparam int APU_DATA_W = 8;
    localparam int DSP_STREAK_MAX_LIMIT = 15;
    typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_DSP, OWN_CPU} owner_t;
endpackage

// File: rtl/apu_arb_sched.sv
// apu_arb_sched: winner selection, DSP streak guard (APU_ARB_STREAK_GUARD_EN) and read-owner register
module apu_arb_sched
    import apu_ram_pkg::*;
#(
    parameter int DSP_STREAK_MAX = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   host_lock,
    input  logic   host_req,
    input  logic   dsp_req,
    input  logic   cpu_req,
    input  logic   host_we,
    input  logic   dsp_we,
    input  logic   cpu_we,
    output owner_t winner,
    output owner_t rd_owner
);
    if (DSP_STREAK_MAX < 1 || DSP_STREAK_MAX > DSP_STREAK_MAX_LIMIT) begin : g_bad_streak
        $error("DSP_STREAK_MAX out of range 1..15");
    end

    logic host_win, dsp_win, cpu_win, win_we, cpu_turn, shared_ok;

`ifdef APU_ARB_STREAK_GUARD_EN
    localparam logic [3:0] STREAK_CAP = 4'(DSP_STREAK_MAX);
    logic [3:0] streak;
    assign cpu_turn = streak == STREAK_CAP;
    // Count consecutive DSP wins while the CPU waits; any CPU win or idle CPU restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak <= '0;
        else if (cpu_win || !cpu_req) streak <= '0;
        else if (dsp_win && streak != STREAK_CAP) streak <= streak + 4'd1;
    end
`else
    assign cpu_turn = 1'b0;
`endif

    // Fixed priority host > DSP > CPU; the CPU jumps the DSP once its turn comes; nothing wins in reset
    always_comb begin
        shared_ok = rst_n && !host_req && !host_lock;
        host_win  = rst_n && host_req;
        dsp_win   = shared_ok && dsp_req && !(cpu_turn && cpu_req);
        cpu_win   = shared_ok && cpu_req && (!dsp_req || cpu_turn);
        winner    = host_win ? OWN_HOST : dsp_win ? OWN_DSP : cpu_win ? OWN_CPU : OWN_NONE;
        win_we    = host_win ? host_we : dsp_win ? dsp_we : cpu_we;
    end

    // Remember who issued a read so its rvalid fires on the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_owner <= OWN_NONE;
        else rd_owner <= (winner != OWN_NONE && !win_we) ? winner : OWN_NONE;
    end
endmodule

// File: rtl/apu_ram_arbiter.sv
// apu_ram_arbiter: shares the 64 KiB audio RAM between host, DSP and CPU (streak guard: APU_ARB_STREAK_GUARD_EN)
module apu_ram_arbiter
    import apu_ram_pkg::*;
#(
    parameter int DSP_STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  host_lock,
    input  logic                  host_req,
    input  logic [APU_ADDR_W-1:0] host_addr,
    input  logic [APU_DATA_W-1:0] host_wdata,
    input  logic                  host_we,
    input  logic                  dsp_req,
    input  logic [APU_ADDR_W-1:0] dsp_addr,
    input  logic [APU_DATA_W-1:0] dsp_wdata,
    input  logic                  dsp_we,
    input  logic                  cpu_req,
    input  logic [APU_ADDR_W-1:0] cpu_addr,
    input  logic [APU_DATA_W-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic                  host_gnt,
    output logic                  dsp_gnt,
    output logic                  cpu_gnt,
    output logic                  host_rvalid,
    output logic                  dsp_rvalid,
    output logic                  cpu_rvalid,
    output logic [APU_DATA_W-1:0] rdata,
    output logic [APU_ADDR_W-1:0] ram_address,
    output logic [APU_DATA_W-1:0] ram_write,
    output logic                  ram_write_enable,
    input  logic [APU_DATA_W-1:0] ram_read
);
    owner_t winner, rd_owner;

    apu_arb_sched #(.DSP_STREAK_MAX(DSP_STREAK_MAX)) u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .host_lock(host_lock),
        .host_req (host_req),
        .dsp_req  (dsp_req),
        .cpu_req  (cpu_req),
        .host_we  (host_we),
        .dsp_we   (dsp_we),
        .cpu_we   (cpu_we),
        .winner   (winner),
        .rd_owner (rd_owner)
    );

    // Route the winner onto the RAM bus; an idle bus is driven to all zeros
    always_comb begin
        host_gnt         = winner == OWN_HOST;
        dsp_gnt          = winner == OWN_DSP;
        cpu_gnt          = winner == OWN_CPU;
        ram_address      = host_gnt ? host_addr  : dsp_gnt ? dsp_addr  : cpu_gnt ? cpu_addr  : '0;
        ram_write        = host_gnt ? host_wdata : dsp_gnt ? dsp_wdata : cpu_gnt ? cpu_wdata : '0;
        ram_write_enable = host_gnt ? host_we    : dsp_gnt ? dsp_we    : cpu_gnt && cpu_we;
        host_rvalid      = rd_owner == OWN_HOST;
        dsp_rvalid       = rd_owner == OWN_DSP;
        cpu_rvalid       = rd_owner == OWN_CPU;
        rdata            = ram_read;
    end
endmodule

// File: tb/tb_apu_ram_arbiter.sv
// tb_apu_ram_arbiter: directed stimulus with a read-data scoreboard for apu_ram_arbiter
module tb_apu_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic host_lock;
    logic host_req, dsp_req, cpu_req;
    logic [15:0] host_addr, dsp_addr, cpu_addr;
    logic [7:0] host_wdata, dsp_wdata, cpu_wdata;
    logic host_we, dsp_we, cpu_we;
    logic host_gnt, dsp_gnt, cpu_gnt;
    logic host_rvalid, dsp_rvalid, cpu_rvalid;
    logic [7:0] rdata, ram_write, ram_read;
    logic [15:0] ram_address;
    logic ram_write_enable;

    typedef struct {
        logic [2:0] port;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    logic [7:0] mem [0:65535];
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apu_ram_arbiter #(.DSP_STREAK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .host_lock(host_lock),
        .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata), .dsp_we(dsp_we),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .host_gnt(host_gnt), .dsp_gnt(dsp_gnt), .cpu_gnt(cpu_gnt),
        .host_rvalid(host_rvalid), .dsp_rvalid(dsp_rvalid), .cpu_rvalid(cpu_rvalid),
        .rdata(rdata), .ram_address(ram_address), .ram_write(ram_write),
        .ram_write_enable(ram_write_enable), .ram_read(ram_read)
    );

    // Synchronous RAM model: one-cycle read latency, write on enable
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ram_read <= mem[ram_address];
        if (ram_write_enable) mem[ram_address] <= ram_write;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Check grants and RAM bus this cycle; optionally queue the read data due next cycle
    task automatic cyc_check(input string nm, input logic [2:0] eg, input logic [15:0] ea,
                             input logic [7:0] ew, input logic ewe, input logic push,
                             input logic [7:0] ed);
        @(negedge clk);
        chk(nm, {host_gnt, dsp_gnt, cpu_gnt, ram_address, ram_write, ram_write_enable},
                {eg, ea, ew, ewe});
        if (push) sbq.push_back('{eg, ed, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest queued read in port, data and cycle
    always @(negedge clk) begin
        if (host_rvalid || dsp_rvalid || cpu_rvalid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rv_unexpected: got rvalid %b expected none", {host_rvalid, dsp_rvalid, cpu_rvalid});
            end else begin
                e = sbq.pop_front();
                chk("rvalid", {29'd0, host_rvalid, dsp_rvalid, cpu_rvalid, rdata, cyc},
                              {29'd0, e.port, e.data, e.cyc});
            end
        end
    end

    initial begin
        mem[16'h00F0] = 8'h5E;
        rst_n = 1'b0; host_lock = 1'b0;
        host_req = 1'b1; dsp_req = 1'b1; cpu_req = 1'b1;
        host_we = 1'b0; dsp_we = 1'b0; cpu_we = 1'b0;
        host_addr = '0; dsp_addr = '0; cpu_addr = '0;
        host_wdata = '0; dsp_wdata = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", {host_gnt, dsp_gnt, cpu_gnt, host_rvalid, dsp_rvalid, cpu_rvalid,
                         ram_address, ram_write, ram_write_enable}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'hA5;
        cyc_check("rel_host_wr", 3'b100, 16'h1234, 8'hA5, 1'b1, 1'b0, 8'h00);
        host_we = 1'b0; host_wdata = 8'h00;
        cyc_check("host_rd", 3'b100, 16'h1234, 8'h00, 1'b0, 1'b1, 8'hA5);
        host_req = 1'b0; dsp_req = 1'b0; cpu_req = 1'b0;
        cyc_check("idle", 3'b000, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);

        host_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h00F0;
        repeat (10) cyc_check("lock_wait", 3'b000, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        host_lock = 1'b0;
        cyc_check("lock_drop", 3'b001, 16'h00F0, 8'h00, 1'b0, 1'b1, 8'h5E);
        cpu_req = 1'b0; host_lock = 1'b1;
        cyc_check("lock_rise", 3'b000, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        host_lock = 1'b0;

        cpu_req = 1'b1;
        @(negedge clk);
        chk("cpu_rd_gnt", {host_gnt, dsp_gnt, cpu_gnt, ram_address}, {3'b001, 16'h00F0});
        #2 rst_n = 1'b0; cpu_req = 1'b0;
        #1 chk("rst_mid", {host_gnt, dsp_gnt, cpu_gnt, host_rvalid, dsp_rvalid, cpu_rvalid,
                           ram_address, ram_write, ram_write_enable}, 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("no_rv_after_rst", {host_rvalid, dsp_rvalid, cpu_rvalid}, 3'b000);
        @(posedge clk);
        #1;

        dsp_req = 1'b1; dsp_we = 1'b1; dsp_addr = 16'h0100; dsp_wdata = 8'h11;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h22;
        cyc_check("pre_d0", 3'b010, 16'h0100, 8'h11, 1'b1, 1'b0, 8'h00);
        cyc_check("pre_d1", 3'b010, 16'h0100, 8'h11, 1'b1, 1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
`ifdef APU_ARB_STREAK_GUARD_EN
            if (i % 5 == 4) cyc_check("pattern_c", 3'b001, 16'h0200, 8'h22, 1'b1, 1'b0, 8'h00);
            else cyc_check("pattern_d", 3'b010, 16'h0100, 8'h11, 1'b1, 1'b0, 8'h00);
`else
            cyc_check("pattern_d", 3'b010, 16'h0100, 8'h11, 1'b1, 1'b0, 8'h00);
`endif
        end

        cpu_req = 1'b0; dsp_addr = 16'hFFFF; dsp_wdata = 8'h3C;
        cyc_check("dsp_wr_ffff", 3'b010, 16'hFFFF, 8'h3C, 1'b1, 1'b0, 8'h00);
        dsp_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFF; cpu_wdata = 8'h00;
        cyc_check("cpu_rd_ffff", 3'b001, 16'hFFFF, 8'h00, 1'b0, 1'b1, 8'h3C);
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0300; host_wdata = 8'h77;
        dsp_req = 1'b1; dsp_addr = 16'h0100; dsp_wdata = 8'h11;
        cyc_check("all_three", 3'b100, 16'h0300, 8'h77, 1'b1, 1'b0, 8'h00);
        host_req = 1'b0; dsp_req = 1'b0; cpu_req = 1'b0;
        cyc_check("final_idle", 3'b000, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
